// File: rtl/perf_counter_bank.sv
// perf_counter_bank: request-edge, array-active and total-cycle counters for one matrix operation,
// read back through a registered indexed port. Define PERF_STALL_EN to add per-channel stall counters.
module perf_counter_bank #(
   parameter int unsigned NUM_CH    = 3,
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned SEL_WIDTH = $clog2(2*NUM_CH+2)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic                 array_start_i,
   input  logic                 array_done_i,
   input  logic                 op_done_i,
   input  logic [NUM_CH-1:0]    req_i,
   input  logic [SEL_WIDTH-1:0] rd_sel_i,
   output logic [CNT_WIDTH-1:0] rd_data_o,
   output logic                 busy_o,
   output logic                 valid_o,
   output logic                 ovf_o
);

   localparam int unsigned IDX_ARRAY = NUM_CH;
   localparam int unsigned IDX_TOTAL = NUM_CH + 1;
`ifdef PERF_STALL_EN
   localparam int unsigned IDX_STALL = NUM_CH + 2;
   localparam int unsigned NUM_CNT   = 2*NUM_CH + 2;
`else
   localparam int unsigned NUM_CNT   = NUM_CH + 2;
`endif
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RUN_PRE   = 3'd1,
      RUN_ARRAY = 3'd2,
      RUN_POST  = 3'd3,
      DONE      = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic                 busy_d, valid_d;
   logic                 run_c, clear_c, sat_hit_c;
   logic [NUM_CH-1:0]    req_q;
   logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
   logic [NUM_CNT-1:0]   inc_c;
   logic [NUM_CNT-1:0]   at_max_c;
   logic [CNT_WIDTH-1:0] rd_mux_c;

   assign run_c   = (state_q == RUN_PRE) || (state_q == RUN_ARRAY) || (state_q == RUN_POST);
   assign clear_c = ((state_q == IDLE) || (state_q == DONE)) && start_i;

   // Next state; op_done wins over the array strobes in the same cycle
   always_comb begin
      state_d = state_q;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) state_d = RUN_PRE;
         end
         RUN_PRE: begin
            if (op_done_i)          state_d = DONE;
            else if (array_start_i) state_d = RUN_ARRAY;
         end
         RUN_ARRAY: begin
            if (op_done_i)         state_d = DONE;
            else if (array_done_i) state_d = RUN_POST;
         end
         RUN_POST: begin
            if (op_done_i) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d == RUN_PRE) || (state_d == RUN_ARRAY) || (state_d == RUN_POST);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         busy_o    <= 1'b0;
         valid_o   <= 1'b0;
         req_q     <= '0;
         rd_data_o <= '0;
      end else begin
         state_q   <= state_d;
         busy_o    <= busy_d;
         valid_o   <= valid_d;
         req_q     <= req_i;
         rd_data_o <= rd_mux_c;
      end
   end

   // Per-counter increment requests, flattened to match the read map
   always_comb begin
      inc_c = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         inc_c[k] = run_c & req_i[k] & ~req_q[k];
      end
      inc_c[IDX_ARRAY] = (state_q == RUN_ARRAY);
      inc_c[IDX_TOTAL] = run_c;
`ifdef PERF_STALL_EN
      for (int k = 0; k < NUM_CH; k++) begin
         inc_c[IDX_STALL + k] = run_c & req_i[k];
      end
`endif
   end

   always_comb begin
      at_max_c = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         at_max_c[i] = (cnt_q[i] == CNT_MAX);
      end
   end

   assign sat_hit_c = |(inc_c & at_max_c);

   // Saturating counters; an increment attempted at all-ones flags overflow
   always_ff @(posedge clk) begin
      if (reset || clear_c) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
         ovf_o <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (inc_c[i] && !at_max_c[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
         end
         if (sat_hit_c) ovf_o <= 1'b1;
      end
   end

   always_comb begin
      rd_mux_c = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (rd_sel_i == SEL_WIDTH'(i)) rd_mux_c = cnt_q[i];
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed windows plus randomized operations scored
// against an event-level reference model; a 4-bit instance shares the stimulus to exercise saturation.
module tb_perf_counter_bank;

   localparam int unsigned NUM_CH    = 3;
   localparam int unsigned SEL_WIDTH = $clog2(2*NUM_CH+2);
   localparam int          NUM_IDX   = 1 << SEL_WIDTH;
   localparam int          MAXC      = 80;
   localparam int          SAT_MAX   = 15;
`ifdef PERF_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic                 clk;
   logic                 reset;
   logic                 start_i, array_start_i, array_done_i, op_done_i;
   logic [NUM_CH-1:0]    req_i;
   logic [SEL_WIDTH-1:0] rd_sel_i;
   logic [31:0]          rd_data_main;
   logic [3:0]           rd_data_sat;
   logic                 busy_main, valid_main, ovf_main;
   logic                 busy_sat, valid_sat, ovf_sat;

   perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .array_start_i(array_start_i),
      .array_done_i(array_done_i), .op_done_i(op_done_i), .req_i(req_i), .rd_sel_i(rd_sel_i),
      .rd_data_o(rd_data_main), .busy_o(busy_main), .valid_o(valid_main), .ovf_o(ovf_main)
   );

   perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(4)) dut_sat (
      .clk(clk), .reset(reset), .start_i(start_i), .array_start_i(array_start_i),
      .array_done_i(array_done_i), .op_done_i(op_done_i), .req_i(req_i), .rd_sel_i(rd_sel_i),
      .rd_data_o(rd_data_sat), .busy_o(busy_sat), .valid_o(valid_sat), .ovf_o(ovf_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [NUM_CH-1:0] req_plan [0:MAXC];
   bit                as_plan  [0:MAXC];
   bit                ad_plan  [0:MAXC];
   bit                st_plan  [0:MAXC];
   int                exp_cnt  [0:NUM_IDX-1];
   bit                exp_ovf_sat;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sat_of(input int v);
      return (v > SAT_MAX) ? SAT_MAX : v;
   endfunction

   task automatic clear_plan();
      for (int c = 0; c <= MAXC; c++) begin
         req_plan[c] = '0;
         as_plan[c]  = 1'b0;
         ad_plan[c]  = 1'b0;
         st_plan[c]  = 1'b0;
      end
   endtask

   // Expected counts from the event timeline: start at cycle 0, op_done at cycle t
   task automatic build_model(input int t);
      int s, d;
      s = -1;
      d = t;
      for (int i = 0; i < NUM_IDX; i++) exp_cnt[i] = 0;
      for (int c = 1; c <= t; c++) if (s < 0 && as_plan[c]) s = c;
      if (s >= 1) for (int c = t; c > s; c--) if (ad_plan[c]) d = c;
      exp_cnt[NUM_CH+1] = t;
      exp_cnt[NUM_CH]   = (s >= 1 && s < t) ? d - s : 0;
      for (int k = 0; k < NUM_CH; k++) begin
         for (int c = 1; c <= t; c++) begin
            if (req_plan[c][k] && !req_plan[c-1][k]) exp_cnt[k]++;
            if (STALL_EN && req_plan[c][k]) exp_cnt[NUM_CH+2+k]++;
         end
      end
      exp_ovf_sat = 1'b0;
      for (int i = 0; i < NUM_IDX; i++) if (exp_cnt[i] > SAT_MAX) exp_ovf_sat = 1'b1;
   endtask

   task automatic run_op(input string tag, input int t);
      rd_sel_i = SEL_WIDTH'(NUM_CH+1);
      start_i  = 1'b1;
      req_i    = req_plan[0];
      tick();
      start_i = 1'b0;
      check({tag, " busy after start"}, 32'(busy_main), 32'd1);
      check({tag, " ovf cleared"}, 32'(ovf_main), 32'd0);
      check({tag, " sat ovf cleared"}, 32'(ovf_sat), 32'd0);
      for (int c = 1; c <= t; c++) begin
         start_i       = st_plan[c];
         array_start_i = as_plan[c];
         array_done_i  = ad_plan[c];
         op_done_i     = (c == t);
         req_i         = req_plan[c];
         tick();
         check($sformatf("%s live total c%0d", tag, c), rd_data_main, 32'(c-1));
         check($sformatf("%s sat live total c%0d", tag, c), 32'(rd_data_sat), 32'(sat_of(c-1)));
         check($sformatf("%s busy c%0d", tag, c), 32'(busy_main), 32'(c < t));
         check($sformatf("%s valid c%0d", tag, c), 32'(valid_main), 32'(c == t));
      end
      start_i = 1'b0; array_start_i = 1'b0; array_done_i = 1'b0; op_done_i = 1'b0;
      build_model(t);
   endtask

   task automatic read_all(input string tag, input bit exp_valid);
      for (int i = 0; i < NUM_IDX; i++) begin
         rd_sel_i = SEL_WIDTH'(i);
         req_i    = NUM_CH'($urandom);
         tick();
         check($sformatf("%s rd%0d", tag, i), rd_data_main, 32'(exp_cnt[i]));
         check($sformatf("%s sat rd%0d", tag, i), 32'(rd_data_sat), 32'(sat_of(exp_cnt[i])));
      end
      check({tag, " valid"}, 32'(valid_main), 32'(exp_valid));
      check({tag, " busy"}, 32'(busy_main), 32'd0);
      check({tag, " ovf"}, 32'(ovf_main), 32'd0);
      check({tag, " sat ovf"}, 32'(ovf_sat), 32'(exp_ovf_sat));
   endtask

   task automatic read_one(input string tag, input int idx, input int exp);
      rd_sel_i = SEL_WIDTH'(idx);
      tick();
      check(tag, rd_data_main, 32'(exp));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int t, s, d;
      reset = 1'b1; start_i = 1'b0; array_start_i = 1'b0; array_done_i = 1'b0;
      op_done_i = 1'b0; req_i = '0; rd_sel_i = '0;
      tick();
      tick();
      reset = 1'b0;
      check("reset busy", 32'(busy_main), 32'd0);
      check("reset valid", 32'(valid_main), 32'd0);
      check("reset ovf", 32'(ovf_main), 32'd0);
      check("reset rd_data", rd_data_main, 32'd0);
      check("reset sat rd_data", 32'(rd_data_sat), 32'd0);

      // request edges while idle must not count
      for (int i = 0; i < 6; i++) begin
         req_i = NUM_CH'(i);
         tick();
      end
      check("idle busy", 32'(busy_main), 32'd0);

      clear_plan();
      as_plan[5] = 1'b1; ad_plan[30] = 1'b1;
      req_plan[2][0] = 1'b1; req_plan[6][0] = 1'b1; req_plan[10][0] = 1'b1;
      req_plan[14][0] = 1'b1; req_plan[18][0] = 1'b1;
      for (int c = 20; c <= 27; c++) req_plan[c][1] = 1'b1;
      run_op("edges", 40);
      read_all("edges", 1'b1);
      read_one("edges req0", 0, 5);
      read_one("edges req1", 1, 1);
      read_one("edges req2", 2, 0);

      clear_plan();
      as_plan[10] = 1'b1; ad_plan[50] = 1'b1;
      run_op("basic", 70);
      read_all("basic", 1'b1);
      read_one("basic total", NUM_CH+1, 70);
      read_one("basic array", NUM_CH, 40);
      check("basic sat ovf", 32'(ovf_sat), 32'd1);

      clear_plan();
      ad_plan[5] = 1'b1; as_plan[20] = 1'b1;
      run_op("prio", 20);
      read_all("prio", 1'b1);
      read_one("prio array", NUM_CH, 0);

      clear_plan();
      ad_plan[3] = 1'b1; as_plan[8] = 1'b1; st_plan[12] = 1'b1;
      ad_plan[15] = 1'b1; as_plan[17] = 1'b1;
      run_op("illegal", 20);
      read_all("illegal", 1'b1);
      read_one("illegal array", NUM_CH, 7);
      read_one("illegal total", NUM_CH+1, 20);

      clear_plan();
      as_plan[2] = 1'b1; ad_plan[25] = 1'b1;
      for (int c = 0; c <= 5; c++) req_plan[c][2] = 1'b1;
      for (int c = 3; c <= 6; c++) req_plan[c][1] = 1'b1;
      for (int c = 10; c <= 13; c++) req_plan[c][1] = 1'b1;
      for (int c = 20; c <= 23; c++) req_plan[c][1] = 1'b1;
      run_op("stall", 30);
      read_all("stall", 1'b1);
      read_one("stall req1", 1, 3);
      read_one("stall req2 held", 2, 0);
      read_one("stall idx6", NUM_CH+3, STALL_EN ? 12 : 0);

      // abort in RUN_ARRAY with a synchronous reset
      clear_plan();
      as_plan[3] = 1'b1;
      start_i = 1'b1; req_i = '0;
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         array_start_i = as_plan[c];
         req_i = NUM_CH'($urandom);
         tick();
      end
      array_start_i = 1'b0;
      check("midop busy before reset", 32'(busy_main), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midop reset busy", 32'(busy_main), 32'd0);
      check("midop reset valid", 32'(valid_main), 32'd0);
      check("midop reset rd_data", rd_data_main, 32'd0);
      for (int i = 0; i < NUM_IDX; i++) exp_cnt[i] = 0;
      exp_ovf_sat = 1'b0;
      read_all("midop", 1'b0);

      for (int r = 0; r < 6; r++) begin
         clear_plan();
         t = $urandom_range(20, 60);
         s = $urandom_range(1, t);
         d = $urandom_range(1, t);
         as_plan[s] = 1'b1;
         ad_plan[d] = 1'b1;
         req_plan[0] = NUM_CH'($urandom);
         for (int c = 1; c <= t; c++) begin
            req_plan[c] = ($urandom_range(0, 2) == 0) ? NUM_CH'($urandom) : req_plan[c-1];
            if ($urandom_range(0, 15) == 0) as_plan[c] = 1'b1;
            if ($urandom_range(0, 15) == 0) ad_plan[c] = 1'b1;
            if ($urandom_range(0, 15) == 0) st_plan[c] = 1'b1;
         end
         run_op($sformatf("rand%0d", r), t);
         read_all($sformatf("rand%0d", r), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
